line_nav_ctrl: RTL
==================

Name: line_nav_ctrl

Overview:
- Parametrised successor to the car's top-level line-follow FSM. Handles an N-sensor tracker bar, a preloaded turn-plan FIFO, debounced junction and line-loss detection, timed stop/settle phases and turn timeouts.
- Sits between `tracker_sensor` and `motor`. Drives a motor mode code plus status for the LEDs.

Parameters:
- N_SENS, 5, tracker sensor count; odd, ≥3; bit N_SENS-1 is leftmost, centre index C = (N_SENS-1)/2.
- START_CYCLES, 100000000, dwell in COUNT before following.
- CONFIRM_CYCLES, 200000, consecutive cycles a junction/loss pattern must persist.
- STOP_CYCLES, 50000000, dwell in STOP before executing the next action.
- TURN_MAX, 300000000, turn timeout in cycles.
- PLAN_DEPTH, 16, turn-plan FIFO entries (power of 2).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- enable, in, 1: run switch; low forces IDLE.
- detect, in, N_SENS: tracker bits, 1 = line seen.
- plan_wr, in, 1: push plan_data (accepted only in IDLE).
- plan_data, in, 2: 00 straight, 01 left, 10 right, 11 finish.
- plan_clr, in, 1: empty the plan FIFO (IDLE only).
- obstacle, in, 1: sonic proximity flag.
- mode, out, 3: 0 STOP, 1 FWD, 2 SOFT_L, 3 SOFT_R, 4 PIVOT_L, 5 PIVOT_R.
- state_o, out, 4: current state encoding.
- plan_count, out, $clog2(PLAN_DEPTH)+1: entries held.
- plan_ovf, out, 1: sticky; set by a push while full.
- done, out, 1: high in FINISH.
- fault, out, 1: high in FAULT.

Behaviour:
- **Reset:** state IDLE, mode 0, plan empty, plan_count 0, plan_ovf 0, done 0, fault 0, all counters 0.
- **States:** IDLE 0, ARM 1, COUNT 2, FOLLOW 3, JCONF 4, LCONF 5, STOP 6, TURN_L 7, TURN_R 8, UTURN 9, FINISH 10, FAULT 11.
- **Enable:** enable=0 puts every state into IDLE on the next edge. The FIFO is kept; plan_ovf is kept.
- **IDLE:** goes to ARM when enable=1.
  - plan_wr with plan_count < PLAN_DEPTH pushes.
  - A push while full is dropped and sets plan_ovf.
  - plan_clr empties the FIFO and clears plan_ovf. plan_clr wins over a simultaneous plan_wr.
  - plan_wr/plan_clr outside IDLE are ignored.
- **ARM:** goes to COUNT when detect has only bit C set.
- **COUNT:** counts START_CYCLES cycles, then goes to FOLLOW. mode stays STOP.
- **FOLLOW steering** (registered mode, 1 cycle after detect):
  - Only bit C set, or a symmetric pattern: FWD.
  - Any set bit left of C and none right of C: SOFT_L.
  - Mirror case: SOFT_R.
- **FOLLOW exits:**
  - All bits set: go to JCONF.
  - All bits clear: go to LCONF.
- **JCONF / LCONF:**
  - Hold the last steering mode.
  - Count consecutive cycles the pattern persists. Any other pattern returns to FOLLOW with the counter cleared.
  - Count reaching CONFIRM_CYCLES goes to STOP and latches the action:
    - JCONF pops the FIFO head.
    - Empty FIFO at JCONF latches finish.
    - LCONF latches U-turn without popping.
- **STOP:** mode STOP for STOP_CYCLES, then dispatches on the latched action:
  - straight → FOLLOW, ignoring an all-set pattern for CONFIRM_CYCLES so the same junction is not re-detected.
  - left → TURN_L.
  - right → TURN_R.
  - U-turn → UTURN.
  - finish → FINISH.
- **TURN_L / TURN_R / UTURN:**
  - Drive PIVOT_L / PIVOT_R / PIVOT_R respectively.
  - Phase 1: wait for bit C clear.
  - Phase 2: wait for bit C set while not all bits are set, then go to FOLLOW.
  - Elapsed cycles ≥ TURN_MAX goes to FAULT.
- **FINISH / FAULT:** mode STOP. Held until enable=0.
- **Simultaneous events:** enable=0 beats all other transitions. A timeout and line-reacquire on the same cycle resolves to FOLLOW.

Optional Feature:
- Macro: OBSTACLE_HALT_EN.
- **Defined:** obstacle=1 in FOLLOW, JCONF, LCONF or a turn state forces mode STOP and freezes every counter and the state. Release resumes on the next cycle with the counts intact.
- **Undefined:** obstacle is ignored; the port remains present.

Test Plan:
Test parameters: N_SENS=5, START_CYCLES=4, CONFIRM_CYCLES=3, STOP_CYCLES=5, TURN_MAX=40.
- Push 01,10,11 in IDLE; enable; detect=00100 → COUNT for 4 cycles → FOLLOW, mode=1. detect=11000 → mode=2; detect=00011 → mode=3.
- In FOLLOW, detect=11111 for 3 cycles → STOP, plan_count 3→2. After 5 cycles → TURN_L, mode=4. detect 00000 then 00100 → FOLLOW.
- detect=11111 for 2 cycles, then 00100 → returns to FOLLOW, plan_count unchanged.
- detect=00000 for 3 cycles → STOP → UTURN, mode=5. No reacquire for 40 cycles → FAULT, fault=1. enable=0 → IDLE.
- Push 17 entries in IDLE → plan_count=16, plan_ovf=1. plan_wr outside IDLE → count unchanged. Empty plan at a junction → FINISH, done=1.
- With OBSTACLE_HALT_EN: obstacle=1 for 10 cycles mid-JCONF at count 2 → mode=0, state held. Release → STOP after 1 more confirmed cycle.

Source files
------------

// File: rtl/line_nav_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_nav_ctrl
// Brief    : Line-follow navigation FSM with an N-sensor tracker bar, a turn-plan
//            FIFO, debounced junction/loss detection and timed stop/turn phases.
//            Optional macro OBSTACLE_HALT_EN enables the obstacle freeze.
// Revision : 1.0 - initial release
// ============================================================================
module line_nav_ctrl #(
    parameter int N_SENS         = 5,
    parameter int START_CYCLES   = 100000000,
    parameter int CONFIRM_CYCLES = 200000,
    parameter int STOP_CYCLES    = 50000000,
    parameter int TURN_MAX       = 300000000,
    parameter int PLAN_DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [N_SENS-1:0]            detect,
    input  logic                         plan_wr,
    input  logic [1:0]                   plan_data,
    input  logic                         plan_clr,
    input  logic                         obstacle,
    output logic [2:0]                   mode,
    output logic [3:0]                   state_o,
    output logic [$clog2(PLAN_DEPTH):0]  plan_count,
    output logic                         plan_ovf,
    output logic                         done,
    output logic                         fault
);

    localparam int c_C      = (N_SENS - 1) / 2;
    localparam int c_PTR_W  = $clog2(PLAN_DEPTH);
    localparam int c_MAX_A  = (START_CYCLES > STOP_CYCLES) ? START_CYCLES : STOP_CYCLES;
    localparam int c_MAX    = (c_MAX_A > TURN_MAX) ? c_MAX_A : TURN_MAX;
    localparam int c_CNT_W  = $clog2(c_MAX + 1);
    localparam int c_CONF_W = $clog2(CONFIRM_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]  c_START_M1 = c_CNT_W'(START_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_STOP_M1  = c_CNT_W'(STOP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_TURN_M1  = c_CNT_W'(TURN_MAX - 1);
    localparam logic [c_CONF_W-1:0] c_CONF     = c_CONF_W'(CONFIRM_CYCLES);
    localparam logic [c_CONF_W-1:0] c_CONF_M1  = c_CONF_W'(CONFIRM_CYCLES - 1);
    localparam logic [c_PTR_W:0]    c_DEPTH    = (c_PTR_W + 1)'(PLAN_DEPTH);
    localparam logic [N_SENS-1:0]   c_C_ONLY   = {{(N_SENS-1){1'b0}}, 1'b1} << c_C;

    localparam logic [2:0] c_M_STOP    = 3'd0;
    localparam logic [2:0] c_M_FWD     = 3'd1;
    localparam logic [2:0] c_M_SOFT_L  = 3'd2;
    localparam logic [2:0] c_M_SOFT_R  = 3'd3;
    localparam logic [2:0] c_M_PIVOT_L = 3'd4;
    localparam logic [2:0] c_M_PIVOT_R = 3'd5;

    // Latched actions: plan codes 0..3 as-is, plus a U-turn code for line loss
    localparam logic [2:0] c_A_STRAIGHT = 3'd0;
    localparam logic [2:0] c_A_LEFT     = 3'd1;
    localparam logic [2:0] c_A_RIGHT    = 3'd2;
    localparam logic [2:0] c_A_FINISH   = 3'd3;
    localparam logic [2:0] c_A_UTURN    = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_ARM    = 4'd1,  S_COUNT  = 4'd2,  S_FOLLOW = 4'd3,
        S_JCONF  = 4'd4,  S_LCONF  = 4'd5,  S_STOP   = 4'd6,  S_TURN_L = 4'd7,
        S_TURN_R = 4'd8,  S_UTURN  = 4'd9,  S_FINISH = 4'd10, S_FAULT  = 4'd11
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_mode, w_mode_nxt;
    logic [2:0]            r_steer, w_steer_nxt, w_steer;
    logic [2:0]            r_act, w_act_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [c_CONF_W-1:0]   r_conf, w_conf_nxt;
    logic [c_CONF_W-1:0]   r_ign, w_ign_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [1:0]            r_mem [PLAN_DEPTH];
    logic [c_PTR_W-1:0]    r_rd, r_wr;
    logic [c_PTR_W:0]      r_count;
    logic                  r_ovf;
    logic                  w_push, w_pop, w_clr, w_ovf_set, w_halt;
    logic                  w_all_set, w_all_clr, w_c_bit, w_left, w_right, w_empty, w_full;

    assign w_all_set = &detect;
    assign w_all_clr = ~|detect;
    assign w_c_bit   = detect[c_C];
    assign w_left    = |detect[N_SENS-1:c_C+1];
    assign w_right   = |detect[c_C-1:0];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);

`ifdef OBSTACLE_HALT_EN
    assign w_halt = obstacle && (r_state inside {S_FOLLOW, S_JCONF, S_LCONF,
                                                 S_TURN_L, S_TURN_R, S_UTURN});
`else
    // Port is kept for pin compatibility; the halt path is compiled out
    assign w_halt = obstacle & 1'b0;
`endif

    // Symmetric or two-sided patterns steer straight
    always_comb begin
        w_steer = c_M_FWD;
        if (w_left && !w_right)
            w_steer = c_M_SOFT_L;
        else if (w_right && !w_left)
            w_steer = c_M_SOFT_R;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_conf_nxt  = r_conf;
        w_ign_nxt   = r_ign;
        w_phase_nxt = r_phase;
        w_act_nxt   = r_act;
        w_steer_nxt = r_steer;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clr       = 1'b0;
        w_ovf_set   = 1'b0;

        // Plan loading is only possible while parked, independent of enable
        if (r_state == S_IDLE) begin
            if (plan_clr)
                w_clr = 1'b1;
            else if (plan_wr) begin
                if (w_full)
                    w_ovf_set = 1'b1;
                else
                    w_push = 1'b1;
            end
        end

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_conf_nxt  = '0;
            w_ign_nxt   = '0;
            w_phase_nxt = 1'b0;
        end else if (!w_halt) begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARM;
                S_ARM: begin
                    if (detect == c_C_ONLY) begin
                        w_state_nxt = S_COUNT;
                        w_cnt_nxt   = '0;
                    end
                end
                S_COUNT: begin
                    if (r_cnt >= c_START_M1) begin
                        w_state_nxt = S_FOLLOW;
                        w_cnt_nxt   = '0;
                    end else
                        w_cnt_nxt = r_cnt + 1'b1;
                end
                S_FOLLOW: begin
                    if (r_ign != '0)
                        w_ign_nxt = r_ign - 1'b1;
                    if (w_all_set && r_ign == '0) begin
                        w_state_nxt = S_JCONF;
                        w_conf_nxt  = c_CONF_W'(1);
                    end else if (w_all_clr) begin
                        w_state_nxt = S_LCONF;
                        w_conf_nxt  = c_CONF_W'(1);
                    end
                end
                S_JCONF, S_LCONF: begin
                    if ((r_state == S_JCONF) ? w_all_set : w_all_clr) begin
                        if (r_conf >= c_CONF_M1) begin
                            w_state_nxt = S_STOP;
                            w_cnt_nxt   = '0;
                            w_conf_nxt  = '0;
                            if (r_state == S_LCONF)
                                w_act_nxt = c_A_UTURN;
                            else if (w_empty)
                                w_act_nxt = c_A_FINISH;
                            else begin
                                w_act_nxt = {1'b0, r_mem[r_rd]};
                                w_pop     = 1'b1;
                            end
                        end else
                            w_conf_nxt = r_conf + 1'b1;
                    end else begin
                        w_state_nxt = S_FOLLOW;
                        w_conf_nxt  = '0;
                    end
                end
                S_STOP: begin
                    if (r_cnt >= c_STOP_M1) begin
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                        case (r_act)
                            c_A_STRAIGHT: begin
                                w_state_nxt = S_FOLLOW;
                                w_ign_nxt   = c_CONF;
                            end
                            c_A_LEFT:  w_state_nxt = S_TURN_L;
                            c_A_RIGHT: w_state_nxt = S_TURN_R;
                            c_A_UTURN: w_state_nxt = S_UTURN;
                            default:   w_state_nxt = S_FINISH;
                        endcase
                    end else
                        w_cnt_nxt = r_cnt + 1'b1;
                end
                S_TURN_L, S_TURN_R, S_UTURN: begin
                    // Reacquire is checked first so it wins over a coincident timeout
                    if (r_phase && w_c_bit && !w_all_set) begin
                        w_state_nxt = S_FOLLOW;
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                    end else if (r_cnt >= c_TURN_M1) begin
                        w_state_nxt = S_FAULT;
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (!w_c_bit)
                            w_phase_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
            if (w_state_nxt == S_FOLLOW)
                w_steer_nxt = w_steer;
        end
    end

    always_comb begin
        w_mode_nxt = c_M_STOP;
        if (!w_halt || !enable) begin
            case (w_state_nxt)
                S_FOLLOW, S_JCONF, S_LCONF: w_mode_nxt = w_steer_nxt;
                S_TURN_L:                   w_mode_nxt = c_M_PIVOT_L;
                S_TURN_R, S_UTURN:          w_mode_nxt = c_M_PIVOT_R;
                default:                    w_mode_nxt = c_M_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= c_M_STOP;
            r_steer <= c_M_FWD;
            r_act   <= c_A_STRAIGHT;
            r_cnt   <= '0;
            r_conf  <= '0;
            r_ign   <= '0;
            r_phase <= 1'b0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_steer <= w_steer_nxt;
            r_act   <= w_act_nxt;
            r_cnt   <= w_cnt_nxt;
            r_conf  <= w_conf_nxt;
            r_ign   <= w_ign_nxt;
            r_phase <= w_phase_nxt;
            if (w_clr) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr    <= r_wr + 1'b1;
                    r_count <= r_count + 1'b1;
                end
                if (w_pop) begin
                    r_rd    <= r_rd + 1'b1;
                    r_count <= r_count - 1'b1;
                end
                if (w_ovf_set)
                    r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= plan_data;
    end

    assign mode       = r_mode;
    assign state_o    = r_state;
    assign plan_count = r_count;
    assign plan_ovf   = r_ovf;
    assign done       = (r_state == S_FINISH);
    assign fault      = (r_state == S_FAULT);

endmodule
`default_nettype wire
